// File: rtl/text_writer_if.sv
// Character stream in, tile write port and cursor out, for the text console front-end.
// master = character source / tile buffer side, slave = text_writer.
interface text_writer_if #(
   parameter int ADDR_COL_WIDTH = 7,
   parameter int ADDR_ROW_WIDTH = 6,
   parameter int DATA_WIDTH     = 7
);
   logic [DATA_WIDTH-1:0]     char_i;
   logic                      char_valid_i;
   logic                      char_ready_o;
   logic                      wr_en_o;
   logic [ADDR_COL_WIDTH-1:0] col_w_o;
   logic [ADDR_ROW_WIDTH-1:0] row_w_o;
   logic [DATA_WIDTH-1:0]     din_o;
   logic [ADDR_COL_WIDTH-1:0] cursor_col_o;
   logic [ADDR_ROW_WIDTH-1:0] cursor_row_o;

   modport master (
      output char_i, char_valid_i,
      input  char_ready_o, wr_en_o, col_w_o, row_w_o, din_o, cursor_col_o, cursor_row_o
   );

   modport slave (
      input  char_i, char_valid_i,
      output char_ready_o, wr_en_o, col_w_o, row_w_o, din_o, cursor_col_o, cursor_row_o
   );
endinterface

// File: rtl/text_writer.sv
// Text console: ASCII stream -> tile writes with cursor; TEXT_WRITER_LINE_CLEAR_EN adds per-row clear.
// Latency: tile write and cursor update one cycle after the handshake; screen clear after reset/FF.
// Backpressure: char_ready_o low for the whole sweep (plus one trailing cycle), else one char per cycle.
module text_writer #(
   parameter int H_TILES        = 100,
   parameter int V_TILES        = 37,
   parameter int ADDR_COL_WIDTH = 7,
   parameter int ADDR_ROW_WIDTH = 6,
   parameter int DATA_WIDTH     = 7
) (
   input  logic         clk_i,
   input  logic         rst_i,
   text_writer_if.slave tw
);
   localparam logic [ADDR_COL_WIDTH-1:0] COL_MAX = ADDR_COL_WIDTH'(H_TILES - 1);
   localparam logic [ADDR_ROW_WIDTH-1:0] ROW_MAX = ADDR_ROW_WIDTH'(V_TILES - 1);
   localparam logic [DATA_WIDTH-1:0] CH_BS    = DATA_WIDTH'(8'h08);
   localparam logic [DATA_WIDTH-1:0] CH_LF    = DATA_WIDTH'(8'h0A);
   localparam logic [DATA_WIDTH-1:0] CH_FF    = DATA_WIDTH'(8'h0C);
   localparam logic [DATA_WIDTH-1:0] CH_CR    = DATA_WIDTH'(8'h0D);
   localparam logic [DATA_WIDTH-1:0] CH_SPACE = DATA_WIDTH'(8'h20);
   localparam logic [DATA_WIDTH-1:0] CH_TILDE = DATA_WIDTH'(8'h7E);

`ifdef TEXT_WRITER_LINE_CLEAR_EN
   typedef enum logic [1:0] {CLEAR = 2'd0, IDLE = 2'd1, LCLEAR = 2'd2} state_t;
`else
   typedef enum logic [1:0] {CLEAR = 2'd0, IDLE = 2'd1} state_t;
`endif

   state_t                    state_q, state_d;
   logic [ADDR_COL_WIDTH-1:0] cur_col_q, cur_col_d;
   logic [ADDR_ROW_WIDTH-1:0] cur_row_q, cur_row_d;
   logic [ADDR_COL_WIDTH-1:0] sw_col_q, sw_col_d;
   logic [ADDR_ROW_WIDTH-1:0] sw_row_q, sw_row_d;
   logic                      sw_end_q, sw_end_d;
   logic                      wr_en_q, wr_en_d;
   logic [ADDR_COL_WIDTH-1:0] col_w_q, col_w_d;
   logic [ADDR_ROW_WIDTH-1:0] row_w_q, row_w_d;
   logic [DATA_WIDTH-1:0]     din_q, din_d;
   logic [ADDR_ROW_WIDTH-1:0] row_inc;
   logic [ADDR_COL_WIDTH-1:0] col_dec;

   assign row_inc = (cur_row_q == ROW_MAX) ? '0 : cur_row_q + ADDR_ROW_WIDTH'(1);
   assign col_dec = cur_col_q - ADDR_COL_WIDTH'(1);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q   <= CLEAR;
         cur_col_q <= '0;
         cur_row_q <= '0;
         sw_col_q  <= '0;
         sw_row_q  <= '0;
         sw_end_q  <= 1'b0;
         wr_en_q   <= 1'b0;
         col_w_q   <= '0;
         row_w_q   <= '0;
         din_q     <= '0;
      end else begin
         state_q   <= state_d;
         cur_col_q <= cur_col_d;
         cur_row_q <= cur_row_d;
         sw_col_q  <= sw_col_d;
         sw_row_q  <= sw_row_d;
         sw_end_q  <= sw_end_d;
         wr_en_q   <= wr_en_d;
         col_w_q   <= col_w_d;
         row_w_q   <= row_w_d;
         din_q     <= din_d;
      end
   end

   // Sweeps hold one extra cycle after their last write so ready never overlaps a sweep strobe.
   always_comb begin
      state_d   = state_q;
      cur_col_d = cur_col_q;
      cur_row_d = cur_row_q;
      sw_col_d  = sw_col_q;
      sw_row_d  = sw_row_q;
      sw_end_d  = sw_end_q;
      wr_en_d   = 1'b0;
      col_w_d   = col_w_q;
      row_w_d   = row_w_q;
      din_d     = din_q;
      case (state_q)
         CLEAR: begin
            if (sw_end_q) begin
               state_d   = IDLE;
               sw_end_d  = 1'b0;
               cur_col_d = '0;
               cur_row_d = '0;
            end else begin
               wr_en_d = 1'b1;
               col_w_d = sw_col_q;
               row_w_d = sw_row_q;
               din_d   = '0;
               if (sw_col_q == COL_MAX) begin
                  sw_col_d = '0;
                  if (sw_row_q == ROW_MAX) begin
                     sw_row_d = '0;
                     sw_end_d = 1'b1;
                  end else begin
                     sw_row_d = sw_row_q + ADDR_ROW_WIDTH'(1);
                  end
               end else begin
                  sw_col_d = sw_col_q + ADDR_COL_WIDTH'(1);
               end
            end
         end
`ifdef TEXT_WRITER_LINE_CLEAR_EN
         LCLEAR: begin
            if (sw_end_q) begin
               state_d  = IDLE;
               sw_end_d = 1'b0;
               sw_row_d = '0;
            end else begin
               wr_en_d = 1'b1;
               col_w_d = sw_col_q;
               row_w_d = sw_row_q;
               din_d   = '0;
               if (sw_col_q == COL_MAX) begin
                  sw_col_d = '0;
                  sw_end_d = 1'b1;
               end else begin
                  sw_col_d = sw_col_q + ADDR_COL_WIDTH'(1);
               end
            end
         end
`endif
         IDLE: begin
            if (tw.char_valid_i) begin
               if (tw.char_i >= CH_SPACE && tw.char_i <= CH_TILDE) begin
                  wr_en_d = 1'b1;
                  col_w_d = cur_col_q;
                  row_w_d = cur_row_q;
                  din_d   = tw.char_i;
                  if (cur_col_q == COL_MAX) begin
                     cur_col_d = '0;
                     cur_row_d = row_inc;
`ifdef TEXT_WRITER_LINE_CLEAR_EN
                     state_d  = LCLEAR;
                     sw_row_d = row_inc;
`endif
                  end else begin
                     cur_col_d = cur_col_q + ADDR_COL_WIDTH'(1);
                  end
               end else begin
                  case (tw.char_i)
                     CH_LF: begin
                        cur_col_d = '0;
                        cur_row_d = row_inc;
`ifdef TEXT_WRITER_LINE_CLEAR_EN
                        state_d  = LCLEAR;
                        sw_row_d = row_inc;
`endif
                     end
                     CH_CR: cur_col_d = '0;
                     CH_BS: begin
                        if (cur_col_q != '0) begin
                           cur_col_d = col_dec;
                           wr_en_d   = 1'b1;
                           col_w_d   = col_dec;
                           row_w_d   = cur_row_q;
                           din_d     = '0;
                        end
                     end
                     CH_FF: begin
                        state_d  = CLEAR;
                        sw_col_d = '0;
                        sw_row_d = '0;
                        sw_end_d = 1'b0;
                     end
                     default: ;
                  endcase
               end
            end
         end
         default: state_d = CLEAR;
      endcase
   end

   assign tw.char_ready_o = (state_q == IDLE);
   assign tw.wr_en_o      = wr_en_q;
   assign tw.col_w_o      = col_w_q;
   assign tw.row_w_o      = row_w_q;
   assign tw.din_o        = din_q;
   assign tw.cursor_col_o = cur_col_q;
   assign tw.cursor_row_o = cur_row_q;
endmodule

// File: tb/tb_text_writer.sv
// Bench for text_writer: randomized character streams scored against a cursor/screen model.
module tb_text_writer;
   localparam int H = 100;
   localparam int V = 37;

   typedef struct {int col; int row; int din; int cyc;} wr_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   errors = 0;
   int   checks = 0;
   int   mcol = 0;
   int   mrow = 0;
   int   hs_cyc = 0;
   wr_t  obs[$];
   wr_t  exp_q[$];

   always #12 clk = ~clk;

   text_writer_if #(.ADDR_COL_WIDTH(7), .ADDR_ROW_WIDTH(6), .DATA_WIDTH(7)) tw();

   text_writer #(.H_TILES(H), .V_TILES(V), .ADDR_COL_WIDTH(7), .ADDR_ROW_WIDTH(6), .DATA_WIDTH(7))
      dut (.clk_i(clk), .rst_i(rst), .tw(tw));

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk)
      if (tw.wr_en_o === 1'b1)
         obs.push_back('{int'(tw.col_w_o), int'(tw.row_w_o), int'(tw.din_o), cyc});

   // Reference screen/cursor behaviour.
   function automatic void new_row();
      mrow = (mrow + 1) % V;
`ifdef TEXT_WRITER_LINE_CLEAR_EN
      for (int c = 0; c < H; c++) exp_q.push_back('{c, mrow, 0, 0});
`endif
   endfunction

   function automatic void model(input int ch);
      if (ch >= 32 && ch <= 126) begin
         exp_q.push_back('{mcol, mrow, ch, 0});
         mcol++;
         if (mcol == H) begin
            mcol = 0;
            new_row();
         end
      end else if (ch == 10) begin
         mcol = 0;
         new_row();
      end else if (ch == 13) begin
         mcol = 0;
      end else if (ch == 8) begin
         if (mcol > 0) begin
            mcol--;
            exp_q.push_back('{mcol, mrow, 0, 0});
         end
      end else if (ch == 12) begin
         for (int i = 0; i < H * V; i++) exp_q.push_back('{i % H, i / H, 0, 0});
         mcol = 0;
         mrow = 0;
      end
   endfunction

   task automatic send(input int ch);
      int n;
      n = 0;
      @(negedge clk);
      tw.char_i = 7'(ch);
      tw.char_valid_i = 1'b1;
      while (tw.char_ready_o !== 1'b1 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      if (tw.char_ready_o !== 1'b1) begin
         checks++; errors++;
         $display("FAIL send_timeout: ready=%b required 1", tw.char_ready_o);
      end
      hs_cyc = cyc;
      @(posedge clk);
      #1 tw.char_valid_i = 1'b0;
   endtask

   task automatic wait_ready();
      int n;
      n = 0;
      repeat (2) @(negedge clk);
      while (tw.char_ready_o !== 1'b1 && n < 6000) begin
         @(negedge clk);
         n++;
      end
      if (tw.char_ready_o !== 1'b1) begin
         checks++; errors++;
         $display("FAIL ready_timeout: ready=%b required 1", tw.char_ready_o);
      end
      #1;
   endtask

   task automatic move_to(input int col, input int row);
      send(13); model(13);
      while (mrow != row) begin
         send(10); model(10);
      end
      for (int i = 0; i < col; i++) begin
         int ch;
         ch = int'($urandom_range(32, 126));
         send(ch); model(ch);
      end
      wait_ready();
      obs.delete();
      exp_q.delete();
   endtask

   task automatic test_reset();
      int rel, n, bad, rdy_cyc;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++;
      if ({tw.char_ready_o, tw.wr_en_o, tw.col_w_o, tw.row_w_o, tw.din_o, tw.cursor_col_o, tw.cursor_row_o} !== '0) begin
         errors++;
         $display("FAIL reset_values: ready=%b wr=%b col=%0d row=%0d din=%0h cur=(%0d,%0d) required all 0",
                  tw.char_ready_o, tw.wr_en_o, tw.col_w_o, tw.row_w_o, tw.din_o, tw.cursor_col_o, tw.cursor_row_o);
      end
      obs.delete();
      rel = cyc;
      rst = 1'b0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tw.char_ready_o !== 1'b1 && n < 5000);
      #1 rdy_cyc = cyc;
      checks++;
      if (obs.size() != H * V) begin
         errors++;
         $display("FAIL clear_count: got %0d strobes required %0d", obs.size(), H * V);
      end
      bad = 0;
      foreach (obs[i])
         if (obs[i].col != i % H || obs[i].row != i / H || obs[i].din != 0 || obs[i].cyc != rel + 1 + i) bad++;
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL clear_order: %0d bad strobes required 0", bad);
      end
      checks++;
      if (rdy_cyc != rel + H * V + 1) begin
         errors++;
         $display("FAIL clear_ready_cycle: ready at +%0d required +%0d", rdy_cyc - rel, H * V + 1);
      end
      checks++;
      if (tw.cursor_col_o !== 7'd0 || tw.cursor_row_o !== 6'd0) begin
         errors++;
         $display("FAIL clear_cursor: (%0d,%0d) required (0,0)", tw.cursor_col_o, tw.cursor_row_o);
      end
      mcol = 0; mrow = 0;
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      int hs_a;
      send(8'h41); model(8'h41); hs_a = hs_cyc;
      send(8'h42); model(8'h42);
      wait_ready();
      checks++;
      if (obs.size() != 2 || obs[0].col != 0 || obs[0].row != 0 || obs[0].din != 8'h41 ||
          obs[1].col != 1 || obs[1].row != 0 || obs[1].din != 8'h42) begin
         errors++;
         $display("FAIL b2b_writes: n=%0d first=(%0d,%0d)=%0h required (0,0)=41 then (1,0)=42",
                  obs.size(), obs.size() > 0 ? obs[0].col : -1, obs.size() > 0 ? obs[0].row : -1,
                  obs.size() > 0 ? obs[0].din : -1);
      end else begin
         checks++;
         if (obs[0].cyc != hs_a + 1 || obs[1].cyc != obs[0].cyc + 1) begin
            errors++;
            $display("FAIL b2b_timing: cycles %0d,%0d required %0d,%0d", obs[0].cyc, obs[1].cyc, hs_a + 1, hs_a + 2);
         end
      end
      checks++;
      if (tw.cursor_col_o !== 7'd2 || tw.cursor_row_o !== 6'd0) begin
         errors++;
         $display("FAIL b2b_cursor: (%0d,%0d) required (2,0)", tw.cursor_col_o, tw.cursor_row_o);
      end
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_wrap();
      int hs, bad;
      move_to(99, 5);
      send(8'h5A); model(8'h5A); hs = hs_cyc;
      checks++;
      if (tw.cursor_col_o !== 7'd0 || tw.cursor_row_o !== 6'd6) begin
         errors++;
         $display("FAIL wrap_cursor: (%0d,%0d) required (0,6)", tw.cursor_col_o, tw.cursor_row_o);
      end
      bad = 0;
`ifdef TEXT_WRITER_LINE_CLEAR_EN
      for (int i = 0; i < H + 1; i++) begin
         @(negedge clk);
         if (tw.char_ready_o !== 1'b0) bad++;
      end
`else
      @(negedge clk);
      if (tw.char_ready_o !== 1'b1) bad++;
`endif
      checks++;
      if (bad != 0) begin
         errors++;
         $display("FAIL wrap_ready: %0d cycles with wrong ready required 0", bad);
      end
      wait_ready();
      bad = 0;
      foreach (exp_q[i])
         if (i >= obs.size() || obs[i].col != exp_q[i].col || obs[i].row != exp_q[i].row ||
             obs[i].din != exp_q[i].din || obs[i].cyc != hs + 1 + i) bad++;
      checks++;
      if (bad != 0 || obs.size() != exp_q.size()) begin
         errors++;
         $display("FAIL wrap_writes: n=%0d bad=%0d required n=%0d bad=0", obs.size(), bad, exp_q.size());
      end
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_lf_cr();
      int bad;
      move_to(3, 36);
      send(10); model(10);
      checks++;
      if (tw.cursor_col_o !== 7'd0 || tw.cursor_row_o !== 6'd0) begin
         errors++;
         $display("FAIL lf_wrap_cursor: (%0d,%0d) required (0,0)", tw.cursor_col_o, tw.cursor_row_o);
      end
      wait_ready();
      bad = 0;
      foreach (exp_q[i])
         if (i >= obs.size() || obs[i].col != exp_q[i].col || obs[i].row != exp_q[i].row || obs[i].din != 0) bad++;
      checks++;
      if (bad != 0 || obs.size() != exp_q.size()) begin
         errors++;
         $display("FAIL lf_writes: n=%0d bad=%0d required n=%0d bad=0", obs.size(), bad, exp_q.size());
      end
      move_to(7, 2);
      send(13); model(13);
      wait_ready();
      checks++;
      if (tw.cursor_col_o !== 7'd0 || tw.cursor_row_o !== 6'd2 || obs.size() != 0) begin
         errors++;
         $display("FAIL cr: cursor (%0d,%0d) strobes %0d required (0,2) strobes 0",
                  tw.cursor_col_o, tw.cursor_row_o, obs.size());
      end
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_bs_other();
      move_to(4, 1);
      send(8); model(8);
      wait_ready();
      checks++;
      if (tw.cursor_col_o !== 7'd3 || tw.cursor_row_o !== 6'd1 || obs.size() != 1 ||
          obs[0].col != 3 || obs[0].row != 1 || obs[0].din != 0) begin
         errors++;
         $display("FAIL bs: cursor (%0d,%0d) strobes %0d required (3,1) one strobe (3,1)=0",
                  tw.cursor_col_o, tw.cursor_row_o, obs.size());
      end
      move_to(0, 1);
      send(8); model(8);
      wait_ready();
      checks++;
      if (tw.cursor_col_o !== 7'd0 || tw.cursor_row_o !== 6'd1 || obs.size() != 0) begin
         errors++;
         $display("FAIL bs_col0: cursor (%0d,%0d) strobes %0d required (0,1) 0",
                  tw.cursor_col_o, tw.cursor_row_o, obs.size());
      end
      send(7); model(7);
      wait_ready();
      checks++;
      if (tw.cursor_col_o !== 7'd0 || tw.cursor_row_o !== 6'd1 || obs.size() != 0) begin
         errors++;
         $display("FAIL other_code: cursor (%0d,%0d) strobes %0d required (0,1) 0",
                  tw.cursor_col_o, tw.cursor_row_o, obs.size());
      end
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_ff();
      int hs, bad;
      move_to(10, 10);
      send(12); model(12); hs = hs_cyc;
      wait_ready();
      bad = 0;
      foreach (exp_q[i])
         if (i >= obs.size() || obs[i].col != exp_q[i].col || obs[i].row != exp_q[i].row ||
             obs[i].din != 0 || obs[i].cyc != hs + 2 + i) bad++;
      checks++;
      if (bad != 0 || obs.size() != H * V) begin
         errors++;
         $display("FAIL ff_clear: n=%0d bad=%0d required n=%0d bad=0", obs.size(), bad, H * V);
      end
      checks++;
      if (tw.cursor_col_o !== 7'd0 || tw.cursor_row_o !== 6'd0) begin
         errors++;
         $display("FAIL ff_cursor: (%0d,%0d) required (0,0)", tw.cursor_col_o, tw.cursor_row_o);
      end
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_reset_mid_clear();
      int n, bad;
      send(12);
      n = 0;
      while (obs.size() < 500 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checks++;
      if (tw.wr_en_o !== 1'b0 || tw.char_ready_o !== 1'b0 || tw.col_w_o !== 7'd0 || tw.row_w_o !== 6'd0) begin
         errors++;
         $display("FAIL midclear_reset: wr=%b ready=%b col=%0d row=%0d required 0 0 0 0",
                  tw.wr_en_o, tw.char_ready_o, tw.col_w_o, tw.row_w_o);
      end
      obs.delete(); exp_q.delete();
      mcol = 0; mrow = 0;
      rst = 1'b0;
      wait_ready();
      bad = 0;
      foreach (obs[i])
         if (obs[i].col != i % H || obs[i].row != i / H || obs[i].din != 0) bad++;
      checks++;
      if (bad != 0 || obs.size() != H * V) begin
         errors++;
         $display("FAIL midclear_restart: n=%0d bad=%0d required n=%0d bad=0", obs.size(), bad, H * V);
      end
      obs.delete(); exp_q.delete();
   endtask

   task automatic test_random();
      int ch, r, bad_cur, bad;
      int others[4] = '{0, 7, 27, 127};
      bad_cur = 0;
      for (int k = 0; k < 300; k++) begin
         r = int'($urandom_range(0, 9));
         if (r <= 5)      ch = int'($urandom_range(32, 126));
         else if (r == 6) ch = 10;
         else if (r == 7) ch = 13;
         else if (r == 8) ch = 8;
         else             ch = others[$urandom_range(0, 3)];
         send(ch); model(ch);
         if (int'(tw.cursor_col_o) != mcol || int'(tw.cursor_row_o) != mrow) bad_cur++;
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      checks++;
      if (bad_cur != 0) begin
         errors++;
         $display("FAIL random_cursor: %0d mismatching cursors required 0", bad_cur);
      end
      wait_ready();
      bad = 0;
      foreach (exp_q[i])
         if (i >= obs.size() || obs[i].col != exp_q[i].col || obs[i].row != exp_q[i].row ||
             obs[i].din != exp_q[i].din) bad++;
      checks++;
      if (bad != 0 || obs.size() != exp_q.size()) begin
         errors++;
         $display("FAIL random_writes: n=%0d bad=%0d required n=%0d bad=0", obs.size(), bad, exp_q.size());
      end
      obs.delete(); exp_q.delete();
   endtask

   initial begin
      tw.char_i = '0;
      tw.char_valid_i = 1'b0;
      test_reset();
      test_back_to_back();
      test_wrap();
      test_lf_cr();
      test_bs_other();
      test_ff();
      test_reset_mid_clear();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #4000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
